usb_tx_scheduler: RTL and testbench
===================================

# usb_tx_scheduler

Transmit-side packet scheduler for the USB host serial path. It arbitrates between handshake, token and data packet requesters and latches the granted request. It then sequences the packet as SYNC, PID, payload field and inline CRC5/CRC16, one bit at a time, into the downstream bit-stuffer. Finally it hands off to the EOP generator. It replaces the fixed-type token-only serialization path and owns all CRC computation for outgoing packets.

## Interface
Parameters:
- MAX_DATA_BYTES, 8, largest data payload in bytes; `dat_len` values above this are clamped to it.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- hs_req  in  1  handshake packet request (level).
- hs_pid  in  4  handshake PID (ACK/NAK/STALL).
- hs_gnt  out  1  one-cycle grant pulse.
- tok_req  in  1  token packet request.
- tok_pid  in  4  token PID.
- tok_addr  in  7  device address.
- tok_endp  in  4  endpoint.
- tok_gnt  out  1  one-cycle grant pulse.
- dat_req  in  1  data packet request.
- dat_pid  in  4  DATA0/DATA1 PID.
- dat_len  in  4  payload byte count, 0..MAX_DATA_BYTES.
- dat_payload  in  8*MAX_DATA_BYTES  payload; byte 0 in [7:0], sent first.
- dat_gnt  out  1  one-cycle grant pulse.
- bit_out  out  1  serial bit to the bit-stuffer.
- bit_valid  out  1  bit_out is valid.
- bit_ready  in  1  stuffer accepts the bit this cycle.
- eop_start  out  1  one-cycle pulse to the EOP generator.
- eop_done  in  1  EOP finished.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SYNC, PID, FIELD, CRC, EOP.
- IDLE: if any request is high, grant by fixed priority hs > tok > dat. The matching *_gnt is high for this cycle only. All inputs of the granted requester are latched. Next state is SYNC. There is no preemption; requests are sampled only in IDLE.
- Bit transfer: a bit completes on a cycle where bit_valid && bit_ready. While bit_ready is low, bit_out and bit_valid hold and the internal bit counter holds.
- SYNC: 8 bits in the order 0,0,0,0,0,0,0,1.
- PID: 8 bits, LSB first. The first four bits are pid[3:0]; the last four are ~pid[3:0].
- FIELD:
  - Token: 11 bits, addr[6:0] then endp[3:0], LSB first.
  - Data: 8*len bits, byte 0 first, each byte LSB first.
  - Handshake packets and len=0 skip FIELD.
- CRC:
  - Every FIELD bit is shifted into the CRC register as it transfers.
  - CRC5: polynomial x^5+x^2+1, initial value 5'b11111.
  - CRC16: polynomial x^16+x^15+x^2+1, initial value 16'hFFFF.
  - The transmitted value is the ones-complement of the remainder, sent so that the 5- or 16-bit field is emitted LSB first.
  - Tokens send 5 CRC bits, data packets 16, handshakes none.
- EOP: after the last bit transfers, bit_valid is low and eop_start pulses for one cycle. Stay in EOP until eop_done, then go to IDLE. A new grant is possible on the IDLE cycle that follows.
- Packet lengths in transferred bits: handshake 16, token 32, data 32+8*len.
- A dat_len above MAX_DATA_BYTES is clamped to MAX_DATA_BYTES at latch time.

## Timing
- Reset: synchronous. On the first posedge with rst=1, the state goes to IDLE and these outputs go to 0: bit_out, bit_valid, hs_gnt, tok_gnt, dat_gnt, eop_start, busy. The CRC register and bit counter clear.
- Reset mid-packet: the packet is abandoned with no EOP. The next request is treated as new.
- Latency: a grant at cycle N puts the first SYNC bit valid at N+1.
- With bit_ready held high, one bit transfers per cycle with no gap between states:
  - last bit at N+L;
  - eop_start at N+L+1.
- Simultaneous requests: only the highest-priority requester is granted. The others must remain asserted to be served later.
- A request dropped during a packet has no effect on that packet.
- eop_done arriving while not in EOP is ignored.
- busy is high from N+1 through the cycle eop_done is sampled.

## Test plan
- Reset: assert rst with all requests high → after the edge, every output is 0 and the state is IDLE; release rst → hs_gnt pulses on the next cycle.
- SETUP token, tok_pid=4'hD, addr=0, endp=0, bit_ready=1 → 32 bits, which as bytes LSB-first are 0x80 0x2D 0x00 0x10 (CRC5 field 5'h02); eop_start at grant+33.
- Zero-length DATA1, dat_pid=4'hB, len=0 → 32 bits: 0x80 0x4B 0x00 0x00.
- ACK handshake, hs_pid=4'h2, with bit_ready low for 3 cycles on PID bit 2 → bytes 0x80 0xD2; bit_out held stable during the stall; total duration 16+3 cycles.
- hs_req, tok_req and dat_req high together → grants occur in the order hs, tok, dat, each in the IDLE cycle after the prior eop_done; no grants overlap.
- Reset asserted while in FIELD of an 8-byte data packet → next cycle is IDLE with no eop_start; a following token is transmitted correctly with a fresh CRC.

Source files
------------

// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: picks one of the handshake, token or data requesters and
// serialises the granted packet into the bit-stuffer. Each packet goes out as
// SYNC, PID, optional field and inline CRC5/CRC16, and the block then hands off
// to the EOP generator. Grants are combinational in the IDLE cycle. The bit
// stream is a mux of registered state, so a stall on bit_ready simply freezes it.
module usb_tx_scheduler #(
    parameter int MAX_DATA_BYTES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hs_req,
    input  logic [3:0]                  hs_pid,
    output logic                        hs_gnt,
    input  logic                        tok_req,
    input  logic [3:0]                  tok_pid,
    input  logic [6:0]                  tok_addr,
    input  logic [3:0]                  tok_endp,
    output logic                        tok_gnt,
    input  logic                        dat_req,
    input  logic [3:0]                  dat_pid,
    input  logic [3:0]                  dat_len,
    input  logic [8*MAX_DATA_BYTES-1:0] dat_payload,
    output logic                        dat_gnt,
    output logic                        bit_out,
    output logic                        bit_valid,
    input  logic                        bit_ready,
    output logic                        eop_start,
    input  logic                        eop_done,
    output logic                        busy
);

    // Field shift register must hold either a full data payload or the
    // 11-bit token field, whichever is wider.
    localparam int FW  = 8 * MAX_DATA_BYTES;
    localparam int FRW = (FW > 11) ? FW : 11;
    // Bit counter spans the longest field and the 16-bit CRC.
    localparam int CW  = ($clog2(FRW + 1) > 5) ? $clog2(FRW + 1) : 5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SYNC  = 3'd1;
    localparam logic [2:0] S_PID   = 3'd2;
    localparam logic [2:0] S_FIELD = 3'd3;
    localparam logic [2:0] S_CRC   = 3'd4;
    localparam logic [2:0] S_EOP   = 3'd5;

    localparam logic [1:0] K_HS  = 2'd0;
    localparam logic [1:0] K_TOK = 2'd1;
    localparam logic [1:0] K_DAT = 2'd2;

    localparam logic [3:0]    MAXL     = 4'(MAX_DATA_BYTES);
    localparam logic [CW-1:0] C_SYNC_L = CW'(7);
    localparam logic [CW-1:0] C_CRC5_L = CW'(4);
    localparam logic [CW-1:0] C_CRC16L = CW'(15);
    localparam logic [CW-1:0] C_TOKLEN = CW'(11);

    logic [2:0]     state_q, state_d;
    logic [1:0]     kind_q, kind_d;
    logic [3:0]     pid_q, pid_d;
    logic [FRW-1:0] field_q, field_d;
    logic [CW-1:0]  flen_q, flen_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4:0]     crc5_q, crc5_d;
    logic [15:0]    crc16_q, crc16_d;
    logic           eop_q, eop_d;

    logic           xfer;
    logic [CW-1:0]  cnt_inc;
    logic [3:0]     len_clamp;
    logic           fb5, fb16;
    logic           any_gnt;

    // Fixed-priority grant, only while idle and never during reset.
    always_comb begin
        hs_gnt  = (state_q == S_IDLE) && !rst && hs_req;
        tok_gnt = (state_q == S_IDLE) && !rst && !hs_req && tok_req;
        dat_gnt = (state_q == S_IDLE) && !rst && !hs_req && !tok_req && dat_req;
        any_gnt = hs_gnt || tok_gnt || dat_gnt;
    end

    // Serial bit selection from the current state and bit counter.
    always_comb begin
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        case (state_q)
            S_SYNC: begin
                bit_valid = 1'b1;
                bit_out   = (cnt_q == C_SYNC_L);
            end
            S_PID: begin
                bit_valid = 1'b1;
                bit_out   = cnt_q[2] ? ~pid_q[cnt_q[1:0]] : pid_q[cnt_q[1:0]];
            end
            S_FIELD: begin
                bit_valid = 1'b1;
                bit_out   = field_q[0];
            end
            S_CRC: begin
                // Remainder is shifted out MSB first, which puts the
                // complemented CRC field on the wire LSB first.
                bit_valid = 1'b1;
                bit_out   = (kind_q == K_TOK) ? ~crc5_q[4] : ~crc16_q[15];
            end
            default: begin
                bit_out   = 1'b0;
                bit_valid = 1'b0;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign eop_start = eop_q;
    assign xfer      = bit_valid && bit_ready;
    assign cnt_inc   = cnt_q + 1'b1;
    assign len_clamp = (dat_len > MAXL) ? MAXL : dat_len;
    assign fb5       = field_q[0] ^ crc5_q[4];
    assign fb16      = field_q[0] ^ crc16_q[15];

    // Packet sequencing: latch on grant, advance one bit per transfer.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        pid_d   = pid_q;
        field_d = field_q;
        flen_d  = flen_q;
        cnt_d   = cnt_q;
        crc5_d  = crc5_q;
        crc16_d = crc16_q;
        eop_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_gnt) begin
                    state_d = S_SYNC;
                    cnt_d   = '0;
                    crc5_d  = 5'h1F;
                    crc16_d = 16'hFFFF;
                    if (hs_gnt) begin
                        kind_d  = K_HS;
                        pid_d   = hs_pid;
                        field_d = '0;
                        flen_d  = '0;
                    end else if (tok_gnt) begin
                        kind_d  = K_TOK;
                        pid_d   = tok_pid;
                        field_d = FRW'({tok_endp, tok_addr});
                        flen_d  = C_TOKLEN;
                    end else begin
                        kind_d  = K_DAT;
                        pid_d   = dat_pid;
                        field_d = FRW'(dat_payload);
                        flen_d  = CW'({len_clamp, 3'b000});
                    end
                end
            end
            S_SYNC: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == C_SYNC_L) begin
                        state_d = S_PID;
                        cnt_d   = '0;
                    end
                end
            end
            S_PID: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == C_SYNC_L) begin
                        cnt_d = '0;
                        if (kind_q == K_HS) begin
                            state_d = S_EOP;
                            eop_d   = 1'b1;
                        end else if (flen_q == '0) begin
                            state_d = S_CRC;
                        end else begin
                            state_d = S_FIELD;
                        end
                    end
                end
            end
            S_FIELD: begin
                if (xfer) begin
                    cnt_d   = cnt_inc;
                    field_d = {1'b0, field_q[FRW-1:1]};
                    crc5_d  = {crc5_q[3:0], 1'b0} ^ (fb5 ? 5'b00101 : 5'b00000);
                    crc16_d = {crc16_q[14:0], 1'b0} ^ (fb16 ? 16'h8005 : 16'h0000);
                    if (cnt_inc == flen_q) begin
                        state_d = S_CRC;
                        cnt_d   = '0;
                    end
                end
            end
            S_CRC: begin
                if (xfer) begin
                    cnt_d   = cnt_inc;
                    crc5_d  = {crc5_q[3:0], 1'b0};
                    crc16_d = {crc16_q[14:0], 1'b0};
                    if (cnt_q == ((kind_q == K_TOK) ? C_CRC5_L : C_CRC16L)) begin
                        state_d = S_EOP;
                        cnt_d   = '0;
                        eop_d   = 1'b1;
                    end
                end
            end
            S_EOP: begin
                if (eop_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            kind_q  <= K_HS;
            pid_q   <= '0;
            field_q <= '0;
            flen_q  <= '0;
            cnt_q   <= '0;
            crc5_q  <= '0;
            crc16_q <= '0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            pid_q   <= pid_d;
            field_q <= field_d;
            flen_q  <= flen_d;
            cnt_q   <= cnt_d;
            crc5_q  <= crc5_d;
            crc16_q <= crc16_d;
            eop_q   <= eop_d;
        end
    end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Bench for usb_tx_scheduler: a packet-level model (queue of expected bits,
// reflected CRC arithmetic) checked every cycle, plus literal packet bytes.
module tb_usb_tx_scheduler;
    localparam int MDB = 8;

    logic clk;
    logic rst;
    logic hs_req, tok_req, dat_req;
    logic [3:0] hs_pid, tok_pid, tok_endp, dat_pid, dat_len;
    logic [6:0] tok_addr;
    logic [8*MDB-1:0] dat_payload;
    logic hs_gnt, tok_gnt, dat_gnt;
    logic bit_out, bit_valid, bit_ready;
    logic eop_start, eop_done, busy;

    usb_tx_scheduler #(.MAX_DATA_BYTES(MDB)) dut (
        .clk(clk), .rst(rst),
        .hs_req(hs_req), .hs_pid(hs_pid), .hs_gnt(hs_gnt),
        .tok_req(tok_req), .tok_pid(tok_pid), .tok_addr(tok_addr),
        .tok_endp(tok_endp), .tok_gnt(tok_gnt),
        .dat_req(dat_req), .dat_pid(dat_pid), .dat_len(dat_len),
        .dat_payload(dat_payload), .dat_gnt(dat_gnt),
        .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .eop_start(eop_start), .eop_done(eop_done), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    bit rst_seen = 0;

    // model: phase 0 idle, 1 sending, 2 eop pulse, 3 waiting eop_done
    int ph = 0;
    bit mq[$];
    int c5, c16;

    // capture of what the DUT actually transferred
    bit cap[$];
    int order[$];
    int g_cyc, e_cyc, n_eop, eop_tmr;
    bit gnt_flag, eop_flag;

    task automatic chk(string nm, longint got, longint expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    task automatic m_byte(logic [7:0] v);
        for (int i = 0; i < 8; i++) mq.push_back(v[i]);
    endtask

    task automatic m_field(bit b);
        mq.push_back(b);
        if (((c5 ^ int'(b)) & 1) != 0) c5 = (c5 >> 1) ^ 'h14; else c5 = c5 >> 1;
        if (((c16 ^ int'(b)) & 1) != 0) c16 = (c16 >> 1) ^ 'hA001; else c16 = c16 >> 1;
    endtask

    task automatic m_crc(int v, int n);
        for (int i = 0; i < n; i++) mq.push_back(v[i]);
    endtask

    task automatic m_build(int kind);
        int n;
        mq.delete();
        c5 = 'h1F;
        c16 = 'hFFFF;
        m_byte(8'h80);
        if (kind == 0) begin
            m_byte({~hs_pid, hs_pid});
        end else if (kind == 1) begin
            m_byte({~tok_pid, tok_pid});
            for (int i = 0; i < 7; i++) m_field(tok_addr[i]);
            for (int i = 0; i < 4; i++) m_field(tok_endp[i]);
            m_crc(~c5 & 'h1F, 5);
        end else begin
            m_byte({~dat_pid, dat_pid});
            n = (int'(dat_len) > MDB) ? MDB : int'(dat_len);
            for (int i = 0; i < 8 * n; i++) m_field(dat_payload[i]);
            m_crc(~c16 & 'hFFFF, 16);
        end
    endtask

    // Per-cycle compare, capture and model advance (called at negedge).
    task automatic sample();
        logic [6:0] got, expv;
        bit e_hs, e_tok, e_dat, e_bit;
        cyc++;
        e_hs  = (ph == 0) && !rst && hs_req;
        e_tok = (ph == 0) && !rst && !hs_req && tok_req;
        e_dat = (ph == 0) && !rst && !hs_req && !tok_req && dat_req;
        e_bit = (ph == 1 && mq.size() > 0) ? mq[0] : 1'b0;
        got  = {hs_gnt, tok_gnt, dat_gnt, bit_valid, bit_out, eop_start, busy};
        expv = {e_hs, e_tok, e_dat, ph == 1, e_bit, ph == 2, ph != 0};
        if (rst_seen) chk("cycle_outputs", got, expv);

        if (rst) begin
            cap.delete();
            eop_tmr = 0;
        end
        if (hs_gnt || tok_gnt || dat_gnt) begin
            cap.delete();
            g_cyc = cyc;
            gnt_flag = 1;
            order.push_back(hs_gnt ? 0 : (tok_gnt ? 1 : 2));
        end
        if (bit_valid && bit_ready) cap.push_back(bit_out);
        if (eop_start) begin
            e_cyc = cyc;
            eop_flag = 1;
            n_eop++;
            eop_tmr = 2;
        end

        if (rst) begin
            ph = 0;
            mq.delete();
        end else begin
            case (ph)
                0: begin
                    if (e_hs) begin m_build(0); ph = 1; end
                    else if (e_tok) begin m_build(1); ph = 1; end
                    else if (e_dat) begin m_build(2); ph = 1; end
                end
                1: begin
                    if (bit_ready) begin
                        void'(mq.pop_front());
                        if (mq.size() == 0) ph = 2;
                    end
                end
                default: ph = eop_done ? 0 : 3;
            endcase
        end
    endtask

    // One clock: check at negedge, then EOP responder drives after posedge.
    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        if (eop_tmr > 0) begin
            eop_tmr--;
            eop_done = (eop_tmr == 0);
        end else begin
            eop_done = 1'b0;
        end
    endtask

    task automatic wait_gnt(string nm);
        int k = 0;
        gnt_flag = 0;
        while (!gnt_flag && k < 100) begin tick(); k++; end
        chk({nm, "_gnt_seen"}, gnt_flag, 1);
    endtask

    task automatic wait_eop(string nm, bit pat);
        int k = 0;
        eop_flag = 0;
        while (!eop_flag && k < 400) begin
            if (pat) bit_ready = (k % 3 != 2);
            tick();
            k++;
        end
        bit_ready = 1'b1;
        chk({nm, "_eop_seen"}, eop_flag, 1);
    endtask

    task automatic chk_pkt(string nm, int nbytes, logic [63:0] expv, int delta);
        logic [63:0] got = '0;
        for (int i = 0; i < cap.size() && i < 64; i++) got[i] = cap[i];
        chk({nm, "_len"}, cap.size(), nbytes * 8);
        chk({nm, "_bits"}, got, expv);
        chk({nm, "_eop_time"}, e_cyc - g_cyc, delta);
    endtask

    initial begin
        int rel, eops;
        logic [63:0] g48;
        rst = 1; bit_ready = 1; eop_done = 0;
        hs_req = 1; hs_pid = 4'h2;
        tok_req = 1; tok_pid = 4'hD; tok_addr = 7'h00; tok_endp = 4'h0;
        dat_req = 1; dat_pid = 4'hB; dat_len = 4'd0;
        dat_payload = 64'h0;
        @(posedge clk);
        #1;
        rst_seen = 1;
        tick();
        tick();
        chk("reset_outputs", {hs_gnt, tok_gnt, dat_gnt, bit_out, bit_valid, eop_start, busy}, 0);

        // release: ACK first, with a 3-cycle stall on PID bit 2
        rst = 0;
        rel = cyc + 1;
        wait_gnt("ack");
        chk("ack_grant_cycle", g_cyc, rel);
        hs_req = 0;
        repeat (10) tick();
        bit_ready = 0;
        repeat (3) tick();
        bit_ready = 1;
        wait_eop("ack", 0);
        chk_pkt("ack", 2, 64'hD280, 20);

        // SETUP token next, with a stray eop_done mid-packet
        wait_gnt("setup");
        tok_req = 0;
        repeat (5) tick();
        eop_done = 1;
        wait_eop("setup", 0);
        chk_pkt("setup", 4, 64'h10002D80, 33);

        // zero-length DATA1
        wait_gnt("zlp");
        dat_req = 0;
        wait_eop("zlp", 0);
        chk_pkt("zlp", 4, 64'h00004B80, 33);
        chk("order_size", order.size(), 3);
        chk("order_0", order[0], 0);
        chk("order_1", order[1], 1);
        chk("order_2", order[2], 2);

        // stray eop_done while idle
        repeat (3) tick();
        eop_done = 1;
        repeat (2) tick();

        // 4-byte DATA0 with bit_ready gaps
        dat_pid = 4'h3; dat_len = 4'd4; dat_payload = 64'h0000_0000_0302_0100;
        dat_req = 1;
        wait_gnt("d4");
        dat_req = 0;
        wait_eop("d4", 1);
        g48 = '0;
        for (int i = 0; i < 48 && i < cap.size(); i++) g48[i] = cap[i];
        chk("d4_len", cap.size(), 64);
        chk("d4_head", g48, 64'h0000_0302_0100_C380);

        // over-long length clamps to 8 bytes
        dat_len = 4'd12; dat_payload = 64'hF0E1_D2C3_B4A5_9687;
        dat_req = 1;
        wait_gnt("clamp");
        dat_req = 0;
        wait_eop("clamp", 0);
        chk("clamp_len", cap.size(), 96);
        chk("clamp_eop_time", e_cyc - g_cyc, 97);

        // reset in the FIELD of an 8-byte packet
        dat_len = 4'd8;
        dat_req = 1;
        wait_gnt("abort");
        dat_req = 0;
        repeat (20) tick();
        eops = n_eop;
        rst = 1;
        tick();
        chk("abort_outputs", {busy, bit_valid, eop_start, bit_out}, 0);
        rst = 0;
        repeat (3) tick();
        chk("abort_no_eop", n_eop, eops);

        // OUT token addr 0x15 endp 0xE with a fresh CRC
        tok_pid = 4'h1; tok_addr = 7'h15; tok_endp = 4'hE;
        tok_req = 1;
        wait_gnt("out");
        tok_req = 0;
        wait_eop("out", 0);
        chk_pkt("out", 4, 64'hEF15E180, 33);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
